spi_tx_ctrl: RTL

Transmit-side sequencer for the SPI serial TX shifter. Owns a small holding buffer for transmit words and arbitrates its fill between CPU bus writes and the TX DMA channel. Presents the next word on spi_tx_data, advances on the shifter's tx_start pulse, and counts frames against spi_tnum. Tracks the CRC phase and reports txe, underrun, busy and done status to the SPI register block.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_tx_buf.sv | 73 +++++++
 rtl/spi_tx_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transmit path: sequencer states, data-frame width
// and frame-counter helpers.
package spi_pkg;

   localparam int unsigned DF_W   = 32;
   localparam int unsigned TNUM_W = 13;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_CRC  = 2'd2,
      ST_DONE = 2'd3
   } tx_state_e;

   // Frame counter increment that sticks at the all-ones value
   function automatic logic [TNUM_W-1:0] sat_inc(input logic [TNUM_W-1:0] v);
      return (v == {TNUM_W{1'b1}}) ? v : v + TNUM_W'(1);
   endfunction

endpackage

// File: rtl/spi_tx_buf.sv
// Circular holding buffer for TX words; pointers carry a wrap bit so full and empty
// are distinguished without a separate counter.
module spi_tx_buf
   import spi_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned DW    = DF_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic                    push,
   input  logic                    pop,
   input  logic [DW-1:0]           wdata,
   output logic [DW-1:0]           rdata,
   output logic [$clog2(DEPTH):0]  count_nxt,
   output logic                    full,
   output logic                    empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];
   logic [CW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count;
   logic          pop_ok;
   logic          push_ok;

   assign count   = wr_ptr_q - rd_ptr_q;
   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign rdata   = mem_q[rd_ptr_q[PW-1:0]];

   // Simultaneous push and pop on a full buffer is legal: the head slot frees as the tail fills
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q[PW-1:0]] = wdata;
            wr_ptr_d                = wr_ptr_q + CW'(1);
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + CW'(1);
         end
      end
      count_nxt = wr_ptr_d - rd_ptr_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/spi_tx_ctrl.sv
// SPI transmit sequencer: fills the holding buffer from bus or DMA, feeds the shifter,
// counts frames against spi_tnum and reports TX status.
module spi_tx_ctrl
   import spi_pkg::*;
#(
   parameter int unsigned     DEPTH       = 2,
   parameter logic [DF_W-1:0] UDR_PATTERN = 32'h0
) (
   input  logic              sclk_tx,
   input  logic              spi_tx_rstn,
   input  logic              spe,
   input  logic              rxonly,
   input  logic              crc_en,
   input  logic [TNUM_W-1:0] spi_tnum,
   input  logic              txdmaen,
   input  logic              dr_wr_en,
   input  logic [DF_W-1:0]   dr_wr_data,
   output logic              dma_req,
   input  logic              dma_ack,
   input  logic [DF_W-1:0]   dma_data,
   input  logic              tx_start,
   input  logic              tx_num_max_en,
   output logic [DF_W-1:0]   spi_tx_data,
   output logic              txe,
   output logic              udr,
   input  logic              udr_clr,
   output logic              wr_ovr,
   output logic              busy,
   output logic              tx_done
);

   localparam int unsigned CW  = $clog2(DEPTH) + 1;
   localparam int unsigned SW  = TNUM_W + 1;

   tx_state_e         state_q, state_d;
   logic [TNUM_W-1:0] frame_cnt_q, frame_cnt_d;
   logic              udr_q, udr_d;
   logic              wr_ovr_q, wr_ovr_d;
   logic              txe_q, txe_d;
   logic              dma_req_q, dma_req_d;
   logic              busy_q, busy_d;
   logic              tx_done_q, tx_done_d;

   logic              abort;
   logic              push_req;
   logic              pop;
   logic [DF_W-1:0]   push_data;
   logic [DF_W-1:0]   buf_rdata;
   logic [CW-1:0]     buf_count_nxt;
   logic              buf_full;
   logic              buf_empty;
   logic [TNUM_W-1:0] tnum_eff;
   logic [TNUM_W-1:0] frame_inc;
   logic              pending;

   assign abort     = ~spe | rxonly;
   assign push_req  = txdmaen ? dma_ack : dr_wr_en;
   assign push_data = txdmaen ? dma_data : dr_wr_data;
   assign pop       = tx_start & (state_q == ST_XFER) & ~buf_empty & ~abort;
   assign tnum_eff  = (spi_tnum == '0) ? TNUM_W'(1) : spi_tnum;
   assign frame_inc = sat_inc(frame_cnt_q);

   spi_tx_buf #(
      .DEPTH (DEPTH),
      .DW    (DF_W)
   ) u_buf (
      .clk       (sclk_tx),
      .rst_n     (spi_tx_rstn),
      .flush     (abort),
      .push      (push_req & ~abort),
      .pop       (pop),
      .wdata     (push_data),
      .rdata     (buf_rdata),
      .count_nxt (buf_count_nxt),
      .full      (buf_full),
      .empty     (buf_empty)
   );

   assign spi_tx_data = buf_empty ? UDR_PATTERN : buf_rdata;

   // Next-state, frame counting, sticky flags and registered status
   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      udr_d       = udr_q & ~udr_clr;
      wr_ovr_d    = wr_ovr_q;

      if ((push_req & buf_full & ~pop & ~abort) | (dr_wr_en & txdmaen)) begin
         wr_ovr_d = 1'b1;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (!abort && !buf_empty) state_d = ST_XFER;
         end
         ST_XFER: begin
            if (tx_start) begin
               frame_cnt_d = frame_inc;
               if (buf_empty && !abort) udr_d = 1'b1;
            end
            if ((tx_start && frame_inc >= tnum_eff) || tx_num_max_en) begin
               state_d = crc_en ? ST_CRC : ST_DONE;
            end
         end
         ST_CRC: begin
            if (tx_start) state_d = ST_DONE;
         end
         ST_DONE: begin
            frame_cnt_d = '0;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (abort) begin
         state_d     = ST_IDLE;
         frame_cnt_d = '0;
      end

      // Status is computed from next-cycle values so each output tracks its register
      pending   = (SW'(frame_cnt_d) + SW'(buf_count_nxt)) < SW'(tnum_eff);
      txe_d     = buf_count_nxt < CW'(DEPTH);
      busy_d    = (state_d != ST_IDLE);
      tx_done_d = (state_d == ST_DONE);
      dma_req_d = txdmaen & ~abort & ((state_d == ST_IDLE) | (state_d == ST_XFER))
                  & (buf_count_nxt < CW'(DEPTH)) & pending;
   end

   always_ff @(posedge sclk_tx) begin
      if (!spi_tx_rstn) begin
         state_q     <= ST_IDLE;
         frame_cnt_q <= '0;
         udr_q       <= 1'b0;
         wr_ovr_q    <= 1'b0;
         txe_q       <= 1'b1;
         dma_req_q   <= 1'b0;
         busy_q      <= 1'b0;
         tx_done_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         udr_q       <= udr_d;
         wr_ovr_q    <= wr_ovr_d;
         txe_q       <= txe_d;
         dma_req_q   <= dma_req_d;
         busy_q      <= busy_d;
         tx_done_q   <= tx_done_d;
      end
   end

   assign udr     = udr_q;
   assign wr_ovr  = wr_ovr_q;
   assign txe     = txe_q;
   assign dma_req = dma_req_q;
   assign busy    = busy_q;
   assign tx_done = tx_done_q;

endmodule
